// File: rtl/addsub_serial_if.sv
// Operation bus for addsub_serial: request/operands in, status/result out.
interface addsub_serial_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic             m;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c;
   logic             v;

   modport master (
      output start, x, y, cin, m,
      input  busy, done, s, c, v
   );

   modport slave (
      input  start, x, y, cin, m,
      output busy, done, s, c, v
   );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: WIDTH bits processed DIGIT bits per cycle, LSB digit first.
// Optional macro ADDSUB_SAT_EN saturates the result on signed overflow.
module addsub_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic           clk,
   input  logic           rst,
   addsub_serial_if.slave bus
);
   localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (DIGIT < 1) begin : g_bad_digit
         $error("addsub_serial: DIGIT must be at least 1");
      end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
         $error("addsub_serial: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   int               idx;
   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] dsum;
   logic             dcout;
   logic [WIDTH-1:0] sum_full;
   logic             ovf;
   logic [WIDTH-1:0] res;

   // One digit of the datapath; b_q already holds ~y for subtract, so this is always an add.
   always_comb begin
      idx      = int'(cnt_q) * DIGIT;
      a_dig    = a_q[idx +: DIGIT];
      b_dig    = b_q[idx +: DIGIT];
      {dcout, dsum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
      sum_full = acc_q;
      sum_full[idx +: DIGIT] = dsum;
      ovf      = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
      if (ovf) begin
         res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         res = sum_full;
      end
`else
      res      = sum_full;
`endif
   end

   // Control FSM and next-state of every register.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      s_d     = s_q;
      c_d     = c_q;
      v_d     = v_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               a_d     = bus.x;
               b_d     = bus.m ? ~bus.y : bus.y;
               carry_d = bus.m ? ~bus.cin : bus.cin;
               cnt_d   = '0;
               acc_d   = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            carry_d = dcout;
            acc_d   = sum_full;
            if (cnt_q == CW'(N - 1)) begin
               state_d = DONE;
               cnt_d   = '0;
               s_d     = res;
               c_d     = dcout;
               v_d     = ovf;
               done_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         c_q     <= c_d;
         v_q     <= v_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.s    = s_q;
   assign bus.c    = c_q;
   assign bus.v    = v_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Directed self-checking bench for addsub_serial (32/8 and 8/1 configurations).
module tb_addsub_serial;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   addsub_serial_if #(.WIDTH(32)) bus_a ();
   addsub_serial_if #(.WIDTH(8))  bus_b ();

   addsub_serial #(.WIDTH(32), .DIGIT(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   addsub_serial #(.WIDTH(8),  .DIGIT(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

`ifdef ADDSUB_SAT_EN
   localparam logic [31:0] EXP_OVF_ADD = 32'h7FFF_FFFF;
   localparam logic [31:0] EXP_OVF_SUB = 32'h8000_0000;
   localparam logic [7:0]  EXP_OVF_B   = 8'h80;
`else
   localparam logic [31:0] EXP_OVF_ADD = 32'h8000_0000;
   localparam logic [31:0] EXP_OVF_SUB = 32'h7FFF_FFFF;
   localparam logic [7:0]  EXP_OVF_B   = 8'h7F;
`endif

   task automatic do_op_a(input logic [31:0] xi, input logic [31:0] yi, input logic ci, input logic mi,
                          output int busy_cnt, output bit done_seen, output logic [31:0] so,
                          output logic co, output logic vo, output logic done_after);
      @(negedge clk);
      bus_a.start = 1'b1; bus_a.x = xi; bus_a.y = yi; bus_a.cin = ci; bus_a.m = mi;
      @(posedge clk);
      @(negedge clk);
      bus_a.start = 1'b0;
      busy_cnt = 0; done_seen = 1'b0;
      for (int k = 0; k < 20 && !done_seen; k++) begin
         if (bus_a.done === 1'b1) begin
            done_seen = 1'b1;
         end else begin
            if (bus_a.busy === 1'b1) busy_cnt++;
            @(negedge clk);
         end
      end
      so = bus_a.s; co = bus_a.c; vo = bus_a.v;
      @(negedge clk);
      done_after = bus_a.done;
   endtask

   task automatic do_op_b(input logic [7:0] xi, input logic [7:0] yi, input logic ci, input logic mi,
                          output int busy_cnt, output bit done_seen, output logic [7:0] so,
                          output logic co, output logic vo);
      @(negedge clk);
      bus_b.start = 1'b1; bus_b.x = xi; bus_b.y = yi; bus_b.cin = ci; bus_b.m = mi;
      @(posedge clk);
      @(negedge clk);
      bus_b.start = 1'b0;
      busy_cnt = 0; done_seen = 1'b0;
      for (int k = 0; k < 30 && !done_seen; k++) begin
         if (bus_b.done === 1'b1) begin
            done_seen = 1'b1;
         end else begin
            if (bus_b.busy === 1'b1) busy_cnt++;
            @(negedge clk);
         end
      end
      so = bus_b.s; co = bus_b.c; vo = bus_b.v;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus_a.start = 1'b1; bus_a.x = 32'h0000_0003; bus_a.y = 32'h0000_0004; bus_a.cin = 1'b0; bus_a.m = 1'b0;
      bus_b.start = 1'b1; bus_b.x = 8'h03; bus_b.y = 8'h04; bus_b.cin = 1'b0; bus_b.m = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
         errors++; $display("FAIL reset_status: busy=%b done=%b expected 0 0", bus_a.busy, bus_a.done);
      end
      checks++;
      if (bus_a.s !== 32'h0 || bus_a.c !== 1'b0 || bus_a.v !== 1'b0) begin
         errors++; $display("FAIL reset_result: s=%h c=%b v=%b expected 00000000 0 0", bus_a.s, bus_a.c, bus_a.v);
      end
      checks++;
      if (bus_b.busy !== 1'b0 || bus_b.s !== 8'h00) begin
         errors++; $display("FAIL reset_b: busy=%b s=%h expected 0 00", bus_b.busy, bus_b.s);
      end
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b0) begin
         errors++; $display("FAIL reset_idle: busy=%b expected 0", bus_a.busy);
      end
   endtask

   task automatic test_add();
      int bc; bit ds; logic [31:0] so; logic co, vo, da;
      do_op_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, bc, ds, so, co, vo, da);
      checks++;
      if (!ds || bc != 4) begin
         errors++; $display("FAIL add_latency: done_seen=%0d busy_cycles=%0d expected 1 4", ds, bc);
      end
      checks++;
      if (so !== 32'h0 || co !== 1'b1 || vo !== 1'b0) begin
         errors++; $display("FAIL add_wrap: s=%h c=%b v=%b expected 00000000 1 0", so, co, vo);
      end
      checks++;
      if (da !== 1'b0) begin
         errors++; $display("FAIL done_pulse: done=%b one cycle later expected 0", da);
      end
      checks++;
      if (bus_a.s !== 32'h0 || bus_a.c !== 1'b1) begin
         errors++; $display("FAIL result_hold: s=%h c=%b expected 00000000 1", bus_a.s, bus_a.c);
      end
      do_op_a(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, bc, ds, so, co, vo, da);
      checks++;
      if (!ds || so !== 32'h0000_0100 || co !== 1'b0 || vo !== 1'b0) begin
         errors++; $display("FAIL add_digit_carry: s=%h c=%b v=%b expected 00000100 0 0", so, co, vo);
      end
   endtask

   task automatic test_sub();
      int bc; bit ds; logic [31:0] so; logic co, vo, da;
      do_op_a(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, bc, ds, so, co, vo, da);
      checks++;
      if (!ds || so !== 32'hFFFF_FFFE || co !== 1'b0 || vo !== 1'b0) begin
         errors++; $display("FAIL sub_neg: s=%h c=%b v=%b expected FFFFFFFE 0 0", so, co, vo);
      end
      do_op_a(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, bc, ds, so, co, vo, da);
      checks++;
      if (!ds || so !== 32'hFFFF_FFFF || co !== 1'b0 || vo !== 1'b0) begin
         errors++; $display("FAIL sub_borrow_in: s=%h c=%b v=%b expected FFFFFFFF 0 0", so, co, vo);
      end
   endtask

   task automatic test_overflow();
      int bc; bit ds; logic [31:0] so; logic co, vo, da;
      do_op_a(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, bc, ds, so, co, vo, da);
      checks++;
      if (!ds || so !== EXP_OVF_ADD || co !== 1'b0 || vo !== 1'b1) begin
         errors++; $display("FAIL ovf_add: s=%h c=%b v=%b expected %h 0 1", so, co, vo, EXP_OVF_ADD);
      end
      do_op_a(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, bc, ds, so, co, vo, da);
      checks++;
      if (!ds || so !== EXP_OVF_SUB || co !== 1'b1 || vo !== 1'b1) begin
         errors++; $display("FAIL ovf_sub: s=%h c=%b v=%b expected %h 1 1", so, co, vo, EXP_OVF_SUB);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ox [3] = '{32'h1234_5678, 32'h0000_0010, 32'hFFFF_FFFF};
      logic [31:0] oy [3] = '{32'h1111_1111, 32'h0000_0003, 32'hFFFF_FFFF};
      logic        oc [3] = '{1'b1, 1'b1, 1'b1};
      logic        om [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] es [3] = '{32'h2345_678A, 32'h0000_000C, 32'hFFFF_FFFF};
      logic        ec [3] = '{1'b0, 1'b1, 1'b1};
      int idx = 0;
      int cyc = 0;
      @(negedge clk);
      bus_a.start = 1'b1; bus_a.x = ox[0]; bus_a.y = oy[0]; bus_a.cin = oc[0]; bus_a.m = om[0];
      for (int k = 0; k < 40 && idx < 3; k++) begin
         @(negedge clk);
         cyc++;
         if (bus_a.done === 1'b1) begin
            checks++;
            if (bus_a.s !== es[idx] || bus_a.c !== ec[idx] || cyc != 5) begin
               errors++;
               $display("FAIL b2b_result%0d: s=%h c=%b period=%0d expected %h %b 5", idx, bus_a.s, bus_a.c, cyc, es[idx], ec[idx]);
            end
            cyc = 0;
            idx++;
            if (idx < 3) begin
               bus_a.x = ox[idx]; bus_a.y = oy[idx]; bus_a.cin = oc[idx]; bus_a.m = om[idx];
            end else begin
               bus_a.start = 1'b0;
            end
         end else begin
            if (cyc == 1) begin
               checks++;
               if (bus_a.busy !== 1'b1) begin
                  errors++; $display("FAIL b2b_no_gap%0d: busy=%b expected 1", idx, bus_a.busy);
               end
            end
            bus_a.x = $urandom; bus_a.y = $urandom; bus_a.cin = ~bus_a.cin; bus_a.m = ~bus_a.m;
         end
      end
      bus_a.start = 1'b0;
      checks++;
      if (idx != 3) begin
         errors++; $display("FAIL b2b_timeout: results=%0d expected 3", idx);
      end
   endtask

   task automatic test_mid_reset();
      int bc; bit ds; logic [31:0] so; logic co, vo, da;
      int done_cnt = 0;
      @(negedge clk);
      bus_a.start = 1'b1; bus_a.x = 32'h0000_1111; bus_a.y = 32'h0000_0002; bus_a.cin = 1'b0; bus_a.m = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus_a.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.s !== 32'h0) begin
         errors++; $display("FAIL mid_reset: busy=%b done=%b s=%h expected 0 0 00000000", bus_a.busy, bus_a.done, bus_a.s);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 0) begin
         errors++; $display("FAIL mid_reset_abort: active_cycles=%0d expected 0", done_cnt);
      end
      do_op_a(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, bc, ds, so, co, vo, da);
      checks++;
      if (!ds || so !== 32'h0000_0007 || co !== 1'b0) begin
         errors++; $display("FAIL after_reset_add: s=%h c=%b expected 00000007 0", so, co);
      end
   endtask

   task automatic test_digit1();
      int bc; bit ds; logic [7:0] so; logic co, vo;
      do_op_b(8'h80, 8'h01, 1'b0, 1'b1, bc, ds, so, co, vo);
      checks++;
      if (!ds || bc != 8) begin
         errors++; $display("FAIL d1_latency: done_seen=%0d busy_cycles=%0d expected 1 8", ds, bc);
      end
      checks++;
      if (so !== EXP_OVF_B || co !== 1'b1 || vo !== 1'b1) begin
         errors++; $display("FAIL d1_sub_ovf: s=%h c=%b v=%b expected %h 1 1", so, co, vo, EXP_OVF_B);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_a.start = 1'b0; bus_a.x = '0; bus_a.y = '0; bus_a.cin = 1'b0; bus_a.m = 1'b0;
      bus_b.start = 1'b0; bus_b.x = '0; bus_b.y = '0; bus_b.cin = 1'b0; bus_b.m = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      test_digit1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
